horner_evaluator: RTL and testbench
===================================

# horner_evaluator

Sequential polynomial evaluator that consumes the 16-bit coefficient lookup table and computes the sum of coef[i]·x^i over the table entries using Horner's rule, one multiply-accumulate per clock. It sits directly downstream of the coefficient LUT:
- it drives the LUT `address` port;
- it reads the LUT `data` port combinationally in the same cycle;
- it delivers a single 16-bit fixed-point result with a one-cycle `done` pulse.

## Interface
- `TERMS`, default 8: number of coefficients evaluated (LUT entries 0..TERMS-1); 2..8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `start` input 1: request an evaluation; sampled only in IDLE.
- `x` input 16: operand, unsigned Q8.8; captured on the accepted `start` edge.
- `address` output 3: LUT address, registered.
- `data` input 16: LUT coefficient, unsigned Q8.8; valid combinationally for the current `address`.
- `busy` output 1: high from the edge after the accepted `start` until the edge that leaves DONE.
- `done` output 1: one-cycle pulse when `result` becomes valid.
- `result` output 16: unsigned Q8.8 polynomial value; holds until the next evaluation completes.

## Operation
- **States:** IDLE, LOAD, MAC, DONE.
- **IDLE:**
  - `start`=1 → capture `x` into `x_reg`, `address`←TERMS-1, go to LOAD.
  - `start`=0 → stay in IDLE.
- **LOAD:** `acc`←`data` (top coefficient), `address`←TERMS-2, go to MAC.
- **MAC:** `acc`←sat_add(sat_mul(`acc`,`x_reg`), `data`).
  - If `address`=0: `result`←new `acc`, go to DONE.
  - Otherwise `address`←`address`-1.
- **DONE:** `done`=1 for exactly this cycle, `address`←0, go to IDLE.
- **sat_mul:** 16×16 → 32-bit product, take bits [23:8].
  - If bits [31:24] are nonzero, output 16'hFFFF.
  - Truncate; no rounding.
- **sat_add:** 17-bit sum; if the carry is set, output 16'hFFFF.
- **Saturation is sticky in practice:** once `acc`=16'hFFFF with `x_reg`≥1.0, later steps stay saturated. No overflow flag is provided.
- **Ignored inputs:** `start` while `busy` is ignored; it is not queued. `x` changes after capture have no effect.
- **Mid-operation reset:** `rst_n` low mid-evaluation aborts on that edge. No `done` pulse is produced, and `result` returns to 0.

## Timing
- **Reset values:** `address`=0, `busy`=0, `done`=0, `result`=16'h0000, `acc`=0, `x_reg`=0, state IDLE.
- **Edge sequence:**
  - Start accepted at edge E0.
  - LOAD at E1.
  - MAC at edges E2..E(TERMS).
  - `done` is high in the cycle following E(TERMS), i.e. it rises at E(TERMS) and falls at E(TERMS+1).
- **Latency:** for TERMS=8, `done` is visible 8 edges after the start edge. `result` is valid from the same edge `done` rises.
- **Back-to-back:** a `start` held high in the `done` cycle is not accepted, because the state is DONE, not IDLE. It is accepted on the following edge. Minimum issue interval is TERMS+2 cycles.
- **`busy` timing:** `busy`=1 during LOAD, MAC and DONE; 0 in IDLE.
- **`address` timing:** `address` is registered and changes only on edges. The LUT has zero latency, so `data` is consumed in the same cycle `address` is presented.

## Structure
- **Package `horner_pkg`:**
  - state enum `{IDLE, LOAD, MAC, DONE}`;
  - constants `Q_FRAC=8`, `Q_ONE=16'h0100`, `Q_MAX=16'hFFFF`;
  - width constants `DATA_W=16`, `ADDR_W=3`.
- **Sub-module `sat_mac`:** purely combinational; inputs `acc`, `x`, `coef`; output the saturated 16-bit Q8.8 `acc*x+coef`. Verified standalone.
- **Top-level FSM:** contains the state register, `address` counter, `x_reg`, `acc`, `result` and the `done`/`busy` decode. The LUT is instantiated alongside it by the parent; it is not inside this block.

## Test plan
- **Zero operand:** reset, then start with `x`=16'h0000 → `result`=16'h0080 (coef[0]); `done` pulses exactly once, 8 edges after start.
- **Unity operand:** `x`=16'h0100 (1.0) → `result`=16'h00A6 (sum of all coefficients); `address` sequence 7,6,5,4,3,2,1,0 observed.
- **Operand 2.0:** `x`=16'h0200 → `result`=16'h01EA. The `acc` trace after LOAD and each MAC step is 1,3,7,16,36,80,181,490.
- **Saturation:** `x`=16'hFFFF → `result`=16'hFFFF, with no wrap to a small value.
- **Protocol:** `start` held high continuously with `x`=16'h0100 → evaluations complete every 10 cycles, each with `result`=16'h00A6. A start pulse mid-MAC does not restart the evaluation.
- **Reset mid-run:** `rst_n` low at MAC cycle 3 → next cycle `busy`=0, `done`=0, `result`=0, `address`=0; a fresh start then completes normally.

Source files
------------

// File: rtl/horner_pkg.sv
// Shared types and constants for the Horner polynomial evaluator.
// Arithmetic is unsigned Q8.8 with saturation to Q_MAX.
package horner_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int Q_FRAC = 8;
  localparam logic [DATA_W-1:0] Q_ONE = 16'h0100;
  localparam logic [DATA_W-1:0] Q_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    DONE
  } state_e;
endpackage

// File: rtl/horner_evaluator_sat_mac.sv
// Saturating Q8.8 multiply-accumulate acc*x+coef; purely combinational, zero latency.
// Both the product and the sum clamp to Q_MAX instead of wrapping.
module sat_mac
  import horner_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] coef,
  output logic [DATA_W-1:0] mac
);

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   mul_sat;
  logic [DATA_W:0]     sum;

  always_comb begin
    prod = acc * x;
    // Any integer bits above Q8.8 range mean overflow; fraction bits are truncated.
    if (|prod[2*DATA_W-1:DATA_W+Q_FRAC]) begin
      mul_sat = Q_MAX;
    end else begin
      mul_sat = prod[DATA_W+Q_FRAC-1:Q_FRAC];
    end
    sum = {1'b0, mul_sat} + {1'b0, coef};
    mac = sum[DATA_W] ? Q_MAX : sum[DATA_W-1:0];
  end

endmodule

// File: rtl/horner_evaluator.sv
// Horner evaluator over an external zero-latency coefficient LUT; done TERMS edges after start.
// start is only accepted in IDLE; requests while busy are dropped, not queued.
module horner_evaluator
  import horner_pkg::*;
#(
  parameter int TERMS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] x,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] mac_w;

  sat_mac u_sat_mac (
    .acc  (acc_q),
    .x    (x_q),
    .coef (data),
    .mac  (mac_w)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    x_d      = x_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          addr_d  = ADDR_W'(TERMS - 1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d   = data;
        addr_d  = ADDR_W'(TERMS - 2);
        state_d = MAC;
      end
      MAC: begin
        acc_d = mac_w;
        if (addr_q == '0) begin
          result_d = mac_w;
          state_d  = DONE;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign address = addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign result  = result_q;

endmodule

// File: tb/tb_horner_evaluator.sv
// Directed bench for horner_evaluator with an 8-entry coefficient LUT model.
// Covers sat_mac standalone, operand table, acc trace, protocol and mid-run reset.
module tb_horner_evaluator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x;
  logic [2:0]  address;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic [15:0] result;

  logic [15:0] m_acc, m_x, m_coef, m_out;

  logic [15:0] lut [8];
  logic [15:0] acc_seen [8];

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [15:0] xv;
    logic [15:0] exp_res;
  } vec_t;

  typedef struct {
    logic [15:0] acc;
    logic [15:0] xv;
    logic [15:0] coef;
    logic [15:0] exp_out;
  } mac_vec_t;

  always #5 clk = ~clk;

  assign data = lut[address];

  horner_evaluator #(.TERMS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .address (address),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  sat_mac u_mac (
    .acc  (m_acc),
    .x    (m_x),
    .coef (m_coef),
    .mac  (m_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one start, observes 20 edges from the accepted start edge (n=0).
  task automatic run_eval(input logic [15:0] xv, input bit mid, output int lat,
                          output logic [15:0] res, output bit addr_ok, output int pulses);
    start   = 1'b1;
    x       = xv;
    lat     = -1;
    res     = '0;
    addr_ok = 1'b1;
    pulses  = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (n <= 7 && address !== 3'(7 - n)) addr_ok = 1'b0;
      if (n >= 1 && n <= 8) acc_seen[n-1] = dut.acc_q;
      if (done === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          res = result;
        end
      end
      if (mid && n == 3) begin
        start = 1'b1;
        x     = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t       vecs [4];
    mac_vec_t   mvecs [7];
    logic [15:0] trace [8];
    int          lat, pulses;
    logic [15:0] res;
    bit          addr_ok;
    int          done_edges [$];
    bit          res_ok;
    int          waited;

    lut[0] = 16'h0080; lut[1] = 16'h0015; lut[2] = 16'h0008; lut[3] = 16'h0004;
    lut[4] = 16'h0002; lut[5] = 16'h0001; lut[6] = 16'h0001; lut[7] = 16'h0001;

    vecs[0] = '{16'h0000, 16'h0080};
    vecs[1] = '{16'h0100, 16'h00A6};
    vecs[2] = '{16'h0200, 16'h01EA};
    vecs[3] = '{16'hFFFF, 16'hFFFF};

    trace[0] = 16'd1;  trace[1] = 16'd3;  trace[2] = 16'd7;   trace[3] = 16'd16;
    trace[4] = 16'd36; trace[5] = 16'd80; trace[6] = 16'd181; trace[7] = 16'd490;

    mvecs[0] = '{16'h0100, 16'h0100, 16'h0001, 16'h0101};
    mvecs[1] = '{16'h0100, 16'hFFFF, 16'h0001, 16'hFFFF};
    mvecs[2] = '{16'h1000, 16'h1000, 16'h0000, 16'hFFFF};
    mvecs[3] = '{16'h8000, 16'h0100, 16'h8000, 16'hFFFF};
    mvecs[4] = '{16'h0180, 16'h0200, 16'h0003, 16'h0303};
    mvecs[5] = '{16'h0001, 16'h0080, 16'h0000, 16'h0000};
    mvecs[6] = '{16'h7FFF, 16'h0100, 16'h0000, 16'h7FFF};

    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    m_acc = '0; m_x = '0; m_coef = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_address", 32'(address), 32'h0);
    chk("reset_busy",    32'(busy),    32'h0);
    chk("reset_done",    32'(done),    32'h0);
    chk("reset_result",  32'(result),  32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      m_acc  = mvecs[i].acc;
      m_x    = mvecs[i].xv;
      m_coef = mvecs[i].coef;
      #1;
      chk($sformatf("sat_mac[%0d]", i), 32'(m_out), 32'(mvecs[i].exp_out));
    end

    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      run_eval(vecs[i].xv, 1'b0, lat, res, addr_ok, pulses);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d_addr_seq", i), 32'(addr_ok), 32'd1);
      chk($sformatf("vec%0d_done_pulses", i), 32'(pulses), 32'd1);
      if (i == 2) begin
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("acc_trace[%0d]", k), 32'(acc_seen[k]), 32'(trace[k]));
        end
      end
    end
    chk("idle_busy", 32'(busy), 32'h0);

    // Start pulse and x change mid-MAC must not disturb the run.
    run_eval(16'h0100, 1'b1, lat, res, addr_ok, pulses);
    chk("mid_start_latency", 32'(lat), 32'd8);
    chk("mid_start_result",  32'(res), 32'h00A6);
    chk("mid_start_pulses",  32'(pulses), 32'd1);

    // start held high: one evaluation every 10 cycles.
    start  = 1'b1;
    x      = 16'h0100;
    res_ok = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_edges.push_back(n);
        if (result !== 16'h00A6) res_ok = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_pulse_count", 32'(done_edges.size()), 32'd4);
    if (done_edges.size() == 4) begin
      chk("held_first_done", 32'(done_edges[0]), 32'd8);
      chk("held_interval_1", 32'(done_edges[1] - done_edges[0]), 32'd10);
      chk("held_interval_3", 32'(done_edges[3] - done_edges[2]), 32'd10);
    end
    chk("held_results", 32'(res_ok), 32'd1);
    waited = 0;
    while (busy === 1'b1 && waited < 12) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("held_return_idle", 32'(busy), 32'h0);

    // Reset asserted at the third MAC edge's cycle.
    start = 1'b1;
    x     = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy",    32'(busy),    32'h0);
    chk("midrst_done",    32'(done),    32'h0);
    chk("midrst_result",  32'(result),  32'h0);
    chk("midrst_address", 32'(address), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_eval(16'h0100, 1'b0, lat, res, addr_ok, pulses);
    chk("post_rst_latency", 32'(lat), 32'd8);
    chk("post_rst_result",  32'(res), 32'h00A6);
    chk("post_rst_addr_seq", 32'(addr_ok), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang, expected finish");
    $fatal(1);
  end

endmodule
